serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Time-shares one instance of the team's single-bit `fullAdder` cell (ports a, b, cin, s, cout) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Sequences operand shifting, carry feedback and result capture.
- Exposes a start/ready/done handshake to the surrounding datapath.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on accept.
- b  input  WIDTH  operand B; captured on accept.
- cin  input  1  carry-in to bit 0; captured on accept.
- ready  output  1  high in IDLE; controller can accept start.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse; sum/cout newly valid.
- sum  output  WIDTH  result of last completed addition; held until next completion.
- cout  output  1  carry-out of bit WIDTH-1 of last completed addition; held.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, at any time):
  - state=IDLE, bit counter=0, internal shift registers=0, carry register=0.
  - sum=0, cout=0, done=0, busy=0, ready=1.
  - An in-flight addition is abandoned; no done pulse follows release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1, busy=0, done=0.
  - start=1 at a rising edge = accept. Load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - start=0: stay.
- RUN:
  - busy=1, ready=0.
  - Shared fullAdder inputs are a_sh[0], b_sh[0], carry.
  - Each edge:
    - a_sh and b_sh shift right by 1.
    - Adder s enters partial-sum register at MSB (shift right).
    - carry<=adder cout.
    - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (last bit):
    - sum<=completed partial sum (including this bit), cout<=adder cout.
    - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle; ready=0, busy=0.
  - Next edge always returns to IDLE.
- Latency:
  - Accept at edge E; RUN occupies edges E+1..E+WIDTH.
  - done is high during the cycle between edges E+WIDTH and E+WIDTH+1.
  - Next accept possible at edge E+WIDTH+2.
  - Throughput is one addition per WIDTH+2 cycles.
- start while RUN or DONE: ignored, not queued.
- a/b/cin changes after accept have no effect on the running addition.
- sum/cout do not change during RUN. They update only on the RUN->DONE edge and otherwise hold the previous result.
- Arithmetic: {cout,sum} == a + b + cin exactly, modulo 2^(WIDTH+1); unsigned.
- Counter width is $clog2(WIDTH); must not wrap before WIDTH-1 is reached.
- All outputs are registered or decoded directly from state; no combinational path from start to any output.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = two's-complement signed overflow of the last completed addition.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured alongside sum/cout on the RUN->DONE edge.
  - Held until next completion; reset value 0.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- Basic add, WIDTH=8: reset, then start with a=0x5A, b=0x3C, cin=0.
  - ready drops the next cycle; busy high for 8 cycles.
  - done pulses once at accept+8; sum=0x96, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Busy rejection: start held high continuously with a=0x01, b=0x02.
  - Operands changed to 0x10/0x20 during RUN.
  - Result is 0x03; done pulse spacing is exactly 10 cycles (WIDTH+2).
- Reset mid-op: assert rst_n=0 four cycles into RUN of 0x80+0x80.
  - All outputs go to reset values immediately (asynchronous), ready=1.
  - No done pulse after release; a fresh 0x01+0x01 yields 0x02.
- Result hold: after 0x12+0x34 -> 0x46, start 0xF0+0x0F.
  - sum stays 0x46 throughout RUN, then changes to 0xFF with cout=0 in the done cycle.
- With SERIAL_ADD_OVF_EN:
  - 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1.
  - 0xFF+0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell adds two WIDTH-bit operands LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | ready for start; operands, carry-in and counter are loaded on accept
// RUN   | one bit per clock through the shared adder, LSB first
// DONE  | one-cycle done pulse; sum/cout hold the new result
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_cout;
  logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fullAdder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        psum_d              = psum_q >> 1;
        psum_d[WIDTH-1]     = fa_s;
        carry_d             = fa_cout;
        cnt_d               = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q is the carry into the MSB while the last bit is being added
          sum_d   = psum_d;
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8), reference model uses plain integer arithmetic.
`timescale 1ns/1ps
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         ready, busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] prev_sum;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int sx, sy, s;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    s  = sx + sy + int'(c);
    return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
  endfunction

  // Runs one addition; observations only, the caller compares.
  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [W-1:0] hold_sum,
                         output int done_m, output int busy_n, output int done_n,
                         output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf,
                         output logic hold_bad, output logic timeout);
    int waitn;
    waitn = 0; timeout = 1'b0; done_m = -1; busy_n = 0; done_n = 0; hold_bad = 1'b0;
    r_sum = '0; r_cout = 1'b0; r_ovf = 1'b0;
    @(negedge clk);
    while (!ready && waitn < 50) begin
      @(negedge clk);
      waitn++;
    end
    if (!ready) begin
      timeout = 1'b1;
      return;
    end
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk);
    for (int m = 0; m <= W + 3; m++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (sum !== hold_sum) hold_bad = 1'b1;
      end
      if (done) begin
        done_n++;
        if (done_m < 0) done_m = m;
        r_sum = sum; r_cout = cout;
`ifdef SERIAL_ADD_OVF_EN
        r_ovf = ovf;
`endif
      end
      if (m == 0) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready); end
    prev_sum = '0;
  endtask

  task automatic test_basic();
    int dm, bn, dn; logic [W-1:0] rs; logic rc, ro, hb, to; logic [W:0] exp;
    exp = model_add(8'h5A, 8'h3C, 1'b0);
    run_add(8'h5A, 8'h3C, 1'b0, prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: ready never seen"); end
    checks++; if (bn != W) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bn, W); end
    checks++; if (dm != W) begin errors++; $display("FAIL basic_done_latency: got %0d want %0d", dm, W); end
    checks++; if (dn != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dn); end
    checks++; if (rs !== exp[W-1:0]) begin errors++; $display("FAIL basic_sum: got %h want %h", rs, exp[W-1:0]); end
    checks++; if (rc !== exp[W]) begin errors++; $display("FAIL basic_cout: got %b want %b", rc, exp[W]); end
    checks++; if (hb !== 1'b0) begin errors++; $display("FAIL basic_hold: sum moved during RUN, want %h", prev_sum); end
    prev_sum = exp[W-1:0];
  endtask

  task automatic test_carry();
    logic [W-1:0] va [2]; logic [W-1:0] vb [2]; logic vc [2];
    int dm, bn, dn; logic [W-1:0] rs; logic rc, ro, hb, to; logic [W:0] exp;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp = model_add(va[i], vb[i], vc[i]);
      run_add(va[i], vb[i], vc[i], prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
      checks++; if (rs !== exp[W-1:0] || to) begin errors++; $display("FAIL carry_sum[%0d]: got %h want %h", i, rs, exp[W-1:0]); end
      checks++; if (rc !== exp[W]) begin errors++; $display("FAIL carry_cout[%0d]: got %b want %b", i, rc, exp[W]); end
      prev_sum = exp[W-1:0];
    end
  endtask

  task automatic test_busy_reject();
    int dt[$]; logic [W-1:0] ds[$]; int waitn;
    waitn = 0;
    @(negedge clk);
    while (!ready && waitn < 50) begin @(negedge clk); waitn++; end
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin dt.push_back(c); ds.push_back(sum); end
      if (c == 0) begin a = 8'h10; b = 8'h20; end
    end
    start = 1'b0;
    checks++; if (dt.size() != 3) begin errors++; $display("FAIL reject_done_count: got %0d want 3", dt.size()); end
    if (dt.size() >= 2) begin
      checks++; if (ds[0] !== 8'h03) begin errors++; $display("FAIL reject_first_sum: got %h want 03", ds[0]); end
      checks++; if (dt[1] - dt[0] != W + 2) begin errors++; $display("FAIL reject_spacing: got %0d want %0d", dt[1] - dt[0], W + 2); end
      checks++; if (ds[1] !== 8'h30) begin errors++; $display("FAIL reject_second_sum: got %h want 30", ds[1]); end
    end
    repeat (3) @(negedge clk);
    prev_sum = 8'h30;
  endtask

  task automatic test_reset_mid();
    int dn, dm, bn, cnt; logic [W-1:0] rs; logic rc, ro, hb, to; int waitn;
    waitn = 0;
    @(negedge clk);
    while (!ready && waitn < 50) begin @(negedge clk); waitn++; end
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midreset_flags: got r=%b b=%b d=%b want 1 0 0", ready, busy, done); end
    checks++; if (sum !== 8'h00 || cout !== 1'b0)
      begin errors++; $display("FAIL midreset_result: got %h/%b want 00/0", sum, cout); end
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", cnt); end
    prev_sum = '0;
    run_add(8'h01, 8'h01, 1'b0, prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
    checks++; if (rs !== 8'h02 || rc !== 1'b0 || dm != W)
      begin errors++; $display("FAIL midreset_fresh: got %h/%b at %0d want 02/0 at %0d", rs, rc, dm, W); end
    prev_sum = 8'h02;
  endtask

  task automatic test_result_hold();
    int dm, bn, dn; logic [W-1:0] rs; logic rc, ro, hb, to;
    run_add(8'h12, 8'h34, 1'b0, prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
    checks++; if (rs !== 8'h46) begin errors++; $display("FAIL hold_first_sum: got %h want 46", rs); end
    prev_sum = 8'h46;
    run_add(8'hF0, 8'h0F, 1'b0, prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
    checks++; if (hb !== 1'b0 || bn != W) begin errors++; $display("FAIL hold_during_run: moved=%b busy=%0d want 0 %0d", hb, bn, W); end
    checks++; if (rs !== 8'hFF || rc !== 1'b0) begin errors++; $display("FAIL hold_new_result: got %h/%b want ff/0", rs, rc); end
    prev_sum = 8'hFF;
  endtask

  task automatic test_random();
    int dm, bn, dn; logic [W-1:0] rs, xa, xb; logic rc, ro, hb, to, xc; logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
      exp = model_add(xa, xb, xc);
      run_add(xa, xb, xc, prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
      checks++;
      if (to || {rc, rs} !== exp || dm != W || dn != 1 || hb) begin
        errors++;
        $display("FAIL random[%0d] %h+%h+%b: got %b_%h lat=%0d pulses=%0d moved=%b want %b_%h lat=%0d",
                 i, xa, xb, xc, rc, rs, dm, dn, hb, exp[W], exp[W-1:0], W);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ro !== model_ovf(xa, xb, xc)) begin
        errors++; $display("FAIL random_ovf[%0d]: got %b want %b", i, ro, model_ovf(xa, xb, xc));
      end
`endif
      prev_sum = exp[W-1:0];
    end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] va [3]; logic [W-1:0] vb [3];
    int dm, bn, dn; logic [W-1:0] rs; logic rc, ro, hb, to; logic [W:0] exp;
    va[0] = 8'h7F; vb[0] = 8'h01;
    va[1] = 8'h80; vb[1] = 8'h80;
    va[2] = 8'hFF; vb[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      exp = model_add(va[i], vb[i], 1'b0);
      run_add(va[i], vb[i], 1'b0, prev_sum, dm, bn, dn, rs, rc, ro, hb, to);
      checks++; if ({rc, rs} !== exp) begin errors++; $display("FAIL ovf_sum[%0d]: got %b_%h want %b_%h", i, rc, rs, exp[W], exp[W-1:0]); end
      checks++; if (ro !== model_ovf(va[i], vb[i], 1'b0)) begin errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, ro, model_ovf(va[i], vb[i], 1'b0)); end
      prev_sum = exp[W-1:0];
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_busy_reject();
    test_reset_mid();
    test_result_hold();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
